// File: rtl/seg7_dec.sv
// seg7_dec: receive-side decoder for the multiplexed two-digit 7-segment bus.
// Synchronizes the active-low segment lines and digit select, waits for a
// settled pattern, decodes it back to a hex nibble and reassembles digit
// pairs into a byte. Illegal lit patterns raise a sticky flag and are counted.
module seg7_dec #(
    parameter int STABLE_CYCLES = 4,  // identical samples required (2..255)
    parameter int SYNC_STAGES   = 2   // synchronizer depth (2..3)
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] seg_n,
    input  logic       digsel,
    input  logic       err_clr,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       err,
    output logic [7:0] bad_cnt
);

    // One synchronized observation of the bus: which digit plus its segments.
    typedef struct packed {
        logic       digsel;
        logic [6:0] seg_n;
    } sample_t;

    // Result of looking a lit pattern up in the hex glyph table.
    typedef struct packed {
        logic       legal;
        logic [3:0] nibble;
    } decode_t;

    // Blank display (all segments off) with the high digit selected.
    localparam sample_t BLANK_SAMPLE = '{digsel: 1'b0, seg_n: 7'h7F};
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    // Map a lit pattern (bit0=a .. bit6=g) to its hex digit, if it is one.
    function automatic decode_t decode_pattern(input logic [6:0] lit);
        decode_t r;
        r = '{legal: 1'b1, nibble: 4'h0};
        case (lit)
            7'h3F: r.nibble = 4'h0;
            7'h06: r.nibble = 4'h1;
            7'h5B: r.nibble = 4'h2;
            7'h4F: r.nibble = 4'h3;
            7'h66: r.nibble = 4'h4;
            7'h6D: r.nibble = 4'h5;
            7'h7D: r.nibble = 4'h6;
            7'h07: r.nibble = 4'h7;
            7'h7F: r.nibble = 4'h8;
            7'h6F: r.nibble = 4'h9;
            7'h77: r.nibble = 4'hA;
            7'h7C: r.nibble = 4'hB;
            7'h39: r.nibble = 4'hC;
            7'h5E: r.nibble = 4'hD;
            7'h79: r.nibble = 4'hE;
            7'h71: r.nibble = 4'hF;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

    // Synchronizer chain and stability-filter state.
    sample_t    sync_q [SYNC_STAGES];
    sample_t    s_cur;
    sample_t    s_prev;
    logic [7:0] run_cnt;
    logic       captured_q;

    // Digit reassembly state.
    logic       seen_hi_q;
    logic       seen_lo_q;

    // Combinational next-state / event signals.
    logic       s_changed;
    logic [7:0] run_nxt;
    logic       captured_kept;
    logic       fire;
    logic [6:0] lit;
    decode_t    dec;
    logic       cap_legal;
    logic       cap_illegal;
    logic [3:0] hi_nxt;
    logic [3:0] lo_nxt;
    logic       seen_hi_nxt;
    logic       seen_lo_nxt;
    logic       pair_done;

    assign s_cur = sync_q[SYNC_STAGES-1];

    // Shift pins through the synchronizer; reset loads a blank display sample.
    always_ff @(posedge clk) begin
        // NOTE: the synchronizer array is reset deliberately: a blank sample
        // after reset is what keeps stale pin history from being captured.
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= BLANK_SAMPLE;
            end
        end else begin
            sync_q[0] <= '{digsel: digsel, seg_n: seg_n};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Run-length filter: count identical samples, fire once per stable run.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here by full if/else coverage), otherwise a latch is inferred.
        s_changed = (s_cur != s_prev);
        if (s_changed) begin
            run_nxt = 8'd1;
        end else if (run_cnt == STABLE_MAX) begin
            run_nxt = run_cnt;
        end else begin
            run_nxt = run_cnt + 8'd1;
        end
        captured_kept = captured_q & ~s_changed;
        fire          = (run_nxt == STABLE_MAX) && !captured_kept;
    end

    // Classify a capture as blank (ignored), legal digit or illegal pattern.
    always_comb begin
        lit         = ~s_cur.seg_n;
        dec         = decode_pattern(lit);
        cap_legal   = fire && dec.legal;
        cap_illegal = fire && !dec.legal && (lit != 7'h00);
    end

    // Digit update and pair completion for the current capture.
    always_comb begin
        hi_nxt      = digit_hi;
        lo_nxt      = digit_lo;
        seen_hi_nxt = seen_hi_q;
        seen_lo_nxt = seen_lo_q;
        pair_done   = 1'b0;
        if (cap_legal) begin
            if (s_cur.digsel) begin
                lo_nxt      = dec.nibble;
                seen_lo_nxt = 1'b1;
            end else begin
                hi_nxt      = dec.nibble;
                seen_hi_nxt = 1'b1;
            end
            // The second distinct digit of a pair completes it; a repeat of
            // the same digit only overwrites and leaves the pair open.
            if (seen_hi_nxt && seen_lo_nxt) begin
                pair_done   = 1'b1;
                seen_hi_nxt = 1'b0;
                seen_lo_nxt = 1'b0;
            end
        end
    end

    // Filter state register; reset marks the (blank) run as already captured.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            s_prev     <= BLANK_SAMPLE;
            run_cnt    <= 8'd0;
            captured_q <= 1'b1;
        end else begin
            s_prev     <= s_cur;
            run_cnt    <= run_nxt;
            captured_q <= captured_kept | fire;
        end
    end

    // Digit, pair and strobe registers; reset discards any partial pair.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            digit_hi   <= 4'h0;
            digit_lo   <= 4'h0;
            seen_hi_q  <= 1'b0;
            seen_lo_q  <= 1'b0;
            data       <= 8'h00;
            data_valid <= 1'b0;
        end else begin
            digit_hi   <= hi_nxt;
            digit_lo   <= lo_nxt;
            seen_hi_q  <= seen_hi_nxt;
            seen_lo_q  <= seen_lo_nxt;
            data_valid <= pair_done;
            if (pair_done) begin
                data <= {hi_nxt, lo_nxt};
            end
        end
    end

    // Sticky error (a new illegal capture beats err_clr) and saturating count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err     <= 1'b0;
            bad_cnt <= 8'h00;
        end else begin
            if (cap_illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            if (cap_illegal && (bad_cnt != 8'hFF)) begin
                bad_cnt <= bad_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_dec.sv
// tb_seg7_dec: directed scenarios plus randomized bus traffic for seg7_dec,
// checked every cycle against a run-length reference model of the decoder.
module tb_seg7_dec;

    localparam int STABLE = 4;
    localparam int NSYNC  = 2;

    logic       clk;
    logic       resetn;
    logic [6:0] seg_n;
    logic       digsel;
    logic       err_clr;
    logic [3:0] digit_hi;
    logic [3:0] digit_lo;
    logic [7:0] data;
    logic       data_valid;
    logic       err;
    logic [7:0] bad_cnt;

    seg7_dec #(
        .STABLE_CYCLES(STABLE),
        .SYNC_STAGES  (NSYNC)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .seg_n     (seg_n),
        .digsel    (digsel),
        .err_clr   (err_clr),
        .digit_hi  (digit_hi),
        .digit_lo  (digit_lo),
        .data      (data),
        .data_valid(data_valid),
        .err       (err),
        .bad_cnt   (bad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Glyph table: index = hex digit, value = lit segments (bit0=a).
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [7:0] delay_q [$];   // pin samples in flight, oldest first
    logic [7:0] last_s;
    int         run_len;       // identical samples seen; > STABLE means done
    logic [3:0] m_hi, m_lo;
    logic [7:0] m_data;
    logic       m_dv, m_err;
    int         m_bad;
    bit         seen_hi, seen_lo;

    function automatic int find_digit(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == p) return i;
        end
        return -1;
    endfunction

    // Advance the model by one rising edge using the current pin values.
    task automatic model_edge();
        logic [7:0] s;
        logic [6:0] p;
        int         d;
        bit         illegal;
        if (!resetn) begin
            delay_q.delete();
            for (int i = 0; i < NSYNC; i++) delay_q.push_back(8'h7F);
            last_s  = 8'h7F;
            run_len = STABLE + 1;
            m_hi = 0; m_lo = 0; m_data = 0; m_dv = 0; m_err = 0; m_bad = 0;
            seen_hi = 0; seen_lo = 0;
            return;
        end
        s = delay_q.pop_front();
        delay_q.push_back({digsel, seg_n});
        m_dv    = 0;
        illegal = 0;
        if (s != last_s) run_len = 1;
        else if (run_len <= STABLE) run_len++;
        last_s = s;
        if (run_len == STABLE) begin
            p = ~s[6:0];
            d = find_digit(p);
            if (p == 7'h00) begin
                // blank display: nothing to do
            end else if (d < 0) begin
                illegal = 1;
                if (m_bad < 255) m_bad++;
            end else begin
                if (s[7]) begin m_lo = 4'(d); seen_lo = 1; end
                else      begin m_hi = 4'(d); seen_hi = 1; end
                if (seen_hi && seen_lo) begin
                    m_data  = {m_hi, m_lo};
                    m_dv    = 1;
                    seen_hi = 0;
                    seen_lo = 0;
                end
            end
        end
        if (illegal)      m_err = 1;
        else if (err_clr) m_err = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    int         strobes;
    logic [7:0] strobe_data;

    // One clock: update model on the edge, compare all outputs mid-cycle.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("digit_hi",   32'(digit_hi),   32'(m_hi));
        check("digit_lo",   32'(digit_lo),   32'(m_lo));
        check("data",       32'(data),       32'(m_data));
        check("data_valid", 32'(data_valid), 32'(m_dv));
        check("err",        32'(err),        32'(m_err));
        check("bad_cnt",    32'(bad_cnt),    32'(m_bad));
        if (data_valid === 1'b1) begin
            strobes++;
            strobe_data = data;
        end
    endtask

    task automatic hold(input logic [6:0] lit, input logic dsel, input int n);
        seg_n  = ~lit;
        digsel = dsel;
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [6:0] rand_illegal();
        logic [6:0] p;
        do p = 7'($urandom); while (p == 7'h00 || find_digit(p) >= 0);
        return p;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] hold_hi, hold_lo;

        // Reset with random pins: all outputs zero after one edge.
        resetn  = 1'b0;
        seg_n   = 7'($urandom);
        digsel  = 1'($urandom);
        err_clr = 1'($urandom);
        @(negedge clk);
        step();
        check("rst_hi",  32'(digit_hi), 0);
        check("rst_lo",  32'(digit_lo), 0);
        check("rst_dat", 32'(data), 0);
        check("rst_dv",  32'(data_valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_bad", 32'(bad_cnt), 0);
        resetn  = 1'b1;
        err_clr = 1'b0;
        strobes = 0;
        hold(7'h00, 1'b0, 8);
        check("blank_no_strobe", 32'(strobes), 0);

        // Pair decode: hi=2 then lo=7, strobe on the 6th edge after the change.
        hold(7'h5B, 1'b0, 8);
        check("pair_hi", 32'(digit_hi), 32'h2);
        seg_n  = ~7'h07;
        digsel = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("pair_dv_timing", 32'(data_valid), (k == 6) ? 1 : 0);
            if (k == 6) check("pair_data", 32'(data), 32'h27);
        end

        // Glitch rejection: 3-sample glitch ignored, 4+ sample change taken.
        hold(7'h06, 1'b1, 8);
        strobes = 0;
        seg_n = ~7'h7F;
        for (int k = 0; k < 3; k++) begin
            step();
            check("glitch_lo_kept", 32'(digit_lo), 32'h1);
        end
        seg_n = ~7'h06;
        for (int k = 0; k < 8; k++) begin
            step();
            check("glitch_lo_kept", 32'(digit_lo), 32'h1);
        end
        check("glitch_no_strobe", 32'(strobes), 0);
        hold(7'h7F, 1'b1, 6);
        check("long_change_lo", 32'(digit_lo), 32'h8);

        // Illegal pattern: one increment per run, err_clr leaves the count.
        hold_hi = digit_hi;
        hold_lo = digit_lo;
        hold(7'h01, 1'b0, 10);
        check("ill_err", 32'(err), 1);
        check("ill_bad", 32'(bad_cnt), 1);
        check("ill_hi_kept", 32'(digit_hi), 32'(hold_hi));
        check("ill_lo_kept", 32'(digit_lo), 32'(hold_lo));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_err", 32'(err), 0);
        check("clr_bad", 32'(bad_cnt), 1);
        for (int r = 0; r < 300; r++) hold((r % 2 == 0) ? 7'h02 : 7'h01, 1'b0, 5);
        check("bad_saturate", 32'(bad_cnt), 255);

        // err_clr held across an illegal capture: set wins on that edge.
        err_clr = 1'b1;
        seg_n   = ~7'h03;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) check("simul_pre", 32'(err), 0);
            if (k == 6) check("simul_set_wins", 32'(err), 1);
        end
        err_clr = 1'b0;

        // Reset mid-pair discards the captured high digit.
        hold(7'h77, 1'b0, 8);
        check("midpair_hi", 32'(digit_hi), 32'hA);
        strobes = 0;
        resetn  = 1'b0;
        seg_n   = ~7'h6D;
        digsel  = 1'b1;
        step();
        resetn = 1'b1;
        hold(7'h6D, 1'b1, 8);
        check("midpair_no_strobe", 32'(strobes), 0);
        check("midpair_lo", 32'(digit_lo), 32'h5);
        hold(7'h4F, 1'b0, 8);
        check("midpair_strobes", 32'(strobes), 1);
        check("midpair_data", 32'(strobe_data), 32'h35);

        // Random traffic: legal, illegal, blank and glitch runs, rare resets.
        for (int seg = 0; seg < 400; seg++) begin
            int         kind;
            int         len;
            logic [6:0] lit;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 8);
            if (kind <= 5)      lit = glyph[$urandom_range(0, 15)];
            else if (kind <= 7) lit = rand_illegal();
            else if (kind == 8) lit = 7'h00;
            else                lit = 7'($urandom);
            seg_n  = ~lit;
            digsel = 1'($urandom);
            for (int c = 0; c < len; c++) begin
                err_clr = ($urandom_range(0, 7) == 0);
                resetn  = ($urandom_range(0, 199) != 0);
                step();
            end
        end
        resetn  = 1'b1;
        err_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
